// File: rtl/exec_pkg.sv
// Shared opcode and FSM state definitions for the execution unit.
// Opcodes 12-15 are unassigned and report as illegal.
package exec_pkg;

    typedef enum logic [3:0] {
        OP_SLL = 4'd0,
        OP_SRL = 4'd1,
        OP_SRA = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_NOR = 4'd8,
        OP_SLT = 4'd9,
        OP_LUI = 4'd10,
        OP_MUL = 4'd11
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Opcodes answered by the external single-cycle ALU.
    function automatic logic is_alu_op(input logic [3:0] ctrl);
        return ctrl <= OP_LUI;
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Shift-add multiplier, one partial product per step; WIDTH steps after start.
// No backpressure: the caller holds step high for exactly the multiply duration.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] accumulator;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] acc_nxt;

    assign acc_nxt = accumulator + (multiplier[0] ? multiplicand : '0);

    // product is the accumulator after the current step, so the final step's
    // sum can be captured on the same edge that done is seen.
    assign product = acc_nxt;
    assign done    = step && (counter == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            multiplicand <= '0;
            multiplier   <= '0;
            accumulator  <= '0;
            counter      <= '0;
        end else if (start) begin
            multiplicand <= op1;
            multiplier   <= op2;
            accumulator  <= '0;
            counter      <= '0;
        end else if (step) begin
            accumulator  <= acc_nxt;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            counter      <= counter + 1'b1;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execution unit: external ALU ops in 1 cycle, MUL in WIDTH+1 cycles, result held in HOLD.
// in_ready follows out_ready in HOLD and is low during MUL; outputs stay stable while stalled.
module exec_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_ctrl,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    import exec_pkg::*;

    state_t           state, state_nxt;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign alu_ctrl  = in_ctrl;
    assign alu_op1   = in_op1;
    assign alu_op2   = in_op2;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (in_ctrl == OP_MUL);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state == ST_MUL);

    mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (accept && is_mul),
        .step    (state == ST_MUL),
        .op1     (in_op1),
        .op2     (in_op2),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = is_mul ? ST_MUL : ST_HOLD;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_nxt = accept ? (is_mul ? ST_MUL : ST_HOLD) : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // accept and mul_done never coincide: in_ready is low throughout MUL.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else if (accept) begin
            out_tag <= in_tag;
            if (is_alu_op(in_ctrl)) begin
                out_result  <= alu_result;
                out_zero    <= alu_zero;
                out_illegal <= 1'b0;
            end else if (!is_mul) begin
                out_result  <= '0;
                out_zero    <= 1'b1;
                out_illegal <= 1'b1;
            end
        end else if (mul_done) begin
            out_result  <= mul_product;
            out_zero    <= (mul_product == '0);
            out_illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a behavioural ALU attached to the alu_* ports.
module tb_exec_unit;
    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_ctrl;
    logic [WIDTH-1:0] in_op1, in_op2;
    logic [TAG_W-1:0] in_tag;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_op1, alu_op2;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    exec_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctrl     (in_ctrl),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .in_tag      (in_tag),
        .alu_ctrl    (alu_ctrl),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_illegal (out_illegal),
        .out_tag     (out_tag),
        .busy        (busy)
    );

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'd0:  alu_result = alu_op1 << alu_op2[4:0];
            4'd1:  alu_result = alu_op1 >> alu_op2[4:0];
            4'd2:  alu_result = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
            4'd3:  alu_result = alu_op1 + alu_op2;
            4'd4:  alu_result = alu_op1 - alu_op2;
            4'd5:  alu_result = alu_op1 & alu_op2;
            4'd6:  alu_result = alu_op1 | alu_op2;
            4'd7:  alu_result = alu_op1 ^ alu_op2;
            4'd8:  alu_result = ~(alu_op1 | alu_op2);
            4'd9:  alu_result = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
            4'd10: alu_result = alu_op2 << 16;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offers one operation, returns 1 time unit after the accepting edge.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_op1   = a;
        in_op2   = b;
        in_tag   = t;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts cycles (relative to accept) until out_valid, with a bound.
    task automatic wait_valid(input int n0, output int n, output int nbusy);
        n = n0;
        nbusy = 0;
        @(negedge clock);
        while (!out_valid && n < 100) begin
            if (busy) nbusy++;
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 4'd3;
        in_op1    = 32'd5;
        in_op2    = 32'd7;
        in_tag    = 4'd1;
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({out_result, out_zero, out_illegal, out_tag} !== '0) begin errors++;
            $display("FAIL reset_outputs got=%h/%b/%b/%h exp=0", out_result, out_zero, out_illegal, out_tag); end
        checks++; if ({alu_ctrl, alu_op1, alu_op2} !== {4'd3, 32'd5, 32'd7}) begin errors++;
            $display("FAIL alu_passthru got=%h/%h/%h exp=3/5/7", alu_ctrl, alu_op1, alu_op2); end
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_add();
        tick();
        issue(4'd3, 32'd5, 32'd7, 4'd3);
        @(negedge clock);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        checks++; if (out_result !== 32'd12) begin errors++; $display("FAIL add_result got=%0d exp=12", out_result); end
        checks++; if (out_zero !== 1'b0 || out_illegal !== 1'b0) begin errors++;
            $display("FAIL add_flags got=%b/%b exp=0/0", out_zero, out_illegal); end
        checks++; if (out_tag !== 4'd3) begin errors++; $display("FAIL add_tag got=%0d exp=3", out_tag); end
        tick();
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_mul();
        int n, nb;
        tick();
        issue(4'd11, 32'd6, 32'd7, 4'd5);
        wait_valid(1, n, nb);
        checks++; if (n !== 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", n); end
        checks++; if (nb !== 32) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=32", nb); end
        checks++; if (out_result !== 32'd42 || out_tag !== 4'd5) begin errors++;
            $display("FAIL mul_6x7 got=%0d tag=%0d exp=42 tag=5", out_result, out_tag); end
        checks++; if (out_zero !== 1'b0 || out_illegal !== 1'b0) begin errors++;
            $display("FAIL mul_flags got=%b/%b exp=0/0", out_zero, out_illegal); end
        tick();
        issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6);
        wait_valid(1, n, nb);
        checks++; if (out_result !== 32'h0000_0001 || n !== 33) begin errors++;
            $display("FAIL mul_ffff got=%h n=%0d exp=00000001 n=33", out_result, n); end
        tick();
        issue(4'd11, 32'h0001_0000, 32'h0001_0000, 4'd7);
        wait_valid(1, n, nb);
        checks++; if (out_result !== 32'd0 || out_zero !== 1'b1 || out_illegal !== 1'b0) begin errors++;
            $display("FAIL mul_wrap got=%h z=%b i=%b exp=0 z=1 i=0", out_result, out_zero, out_illegal); end
    endtask

    task automatic test_illegal();
        int n, nb;
        tick();
        issue(4'hF, 32'd123, 32'd456, 4'd9);
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd0 || out_zero !== 1'b1 ||
                      out_illegal !== 1'b1 || out_tag !== 4'd9) begin errors++;
            $display("FAIL illegal_op got=v%b r=%h z=%b i=%b t=%0d exp=v1 r=0 z=1 i=1 t=9",
                     out_valid, out_result, out_zero, out_illegal, out_tag); end
        tick();
        issue(4'd11, 32'd3, 32'd4, 4'd2);
        in_valid = 1'b1;
        in_ctrl  = 4'd3;
        in_tag   = 4'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++;
                $display("FAIL mul_in_ready got=rdy%b busy%b exp=rdy0 busy1", in_ready, busy); end
            tick();
        end
        in_valid = 1'b0;
        wait_valid(6, n, nb);
        checks++; if (n !== 33 || out_result !== 32'd12 || out_tag !== 4'd2) begin errors++;
            $display("FAIL mul_ignore got=n%0d r=%0d t=%0d exp=n33 r=12 t=2", n, out_result, out_tag); end
        tick();
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_no_extra got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        tick();
        in_valid = 1'b1; in_ctrl = 4'd4; in_op1 = 32'd10; in_op2 = 32'd3; in_tag = 4'd1;
        tick();
        in_ctrl = 4'd7; in_op1 = 32'hF0; in_op2 = 32'hFF; in_tag = 4'd2;
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd7 || in_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_sub got=v%b r=%0d rdy=%b exp=v1 r=7 rdy=1", out_valid, out_result, in_ready); end
        tick();
        in_ctrl = 4'd3; in_op1 = 32'd1; in_op2 = 32'd1; in_tag = 4'd8;
        out_ready = 1'b0;
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h0F || out_tag !== 4'd2) begin errors++;
            $display("FAIL b2b_xor got=v%b r=%h t=%0d exp=v1 r=0f t=2", out_valid, out_result, out_tag); end
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clock);
            checks++; if (out_valid !== 1'b1 || out_result !== 32'h0F || out_tag !== 4'd2 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold got=v%b r=%h t=%0d rdy=%b exp=v1 r=0f t=2 rdy=0",
                         out_valid, out_result, out_tag, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        tick();
        issue(4'd11, 32'd6, 32'd7, 4'd5);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_mid_mul got=b%b v%b rdy%b exp=b0 v0 rdy1", busy, out_valid, in_ready); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL reset_discard got=%0d exp=0", seen); end
        tick();
        issue(4'd3, 32'd1, 32'd1, 4'd4);
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd2 || out_tag !== 4'd4) begin errors++;
            $display("FAIL add_after_reset got=v%b r=%0d t=%0d exp=v1 r=2 t=4", out_valid, out_result, out_tag); end
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0 || out_result !== 32'd0) begin errors++;
            $display("FAIL reset_in_hold got=v%b r=%0d exp=v0 r=0", out_valid, out_result); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_illegal();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter WIDTH, 32, operand/result width.
REQ-002 Parameter TAG_W, 4, width of the opaque tag carried with each operation.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream offers an operation.
REQ-006 in_ready  output  1  unit accepts the operation this cycle.
REQ-007 in_ctrl  input  4  opcode: SLL 0, SRL 1, SRA 2, ADD 3, SUB 4, AND 5, OR 6, XOR 7, NOR 8, SLT 9, LUI 10, MUL 11.
REQ-008 in_op1, in_op2  input  WIDTH  operands.
REQ-009 in_tag  input  TAG_W  opaque tag.
REQ-010 alu_ctrl, alu_op1, alu_op2  output  4/WIDTH/WIDTH  drive the combinational ALU; combinationally equal to in_ctrl/in_op1/in_op2.
REQ-011 alu_result  input  WIDTH; alu_zero  input  1  combinational ALU response.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_result  output  WIDTH; out_zero  output  1; out_illegal  output  1; out_tag  output  TAG_W.
REQ-015 busy  output  1  high while state is MUL.

Function
REQ-016 FSM states SHALL be IDLE, MUL, HOLD.
REQ-017 in_ready SHALL be 1 in IDLE, out_ready in HOLD, 0 in MUL.
REQ-018 An operation is accepted when in_valid && in_ready.
REQ-019 Accepted opcode 0-10 SHALL register alu_result, alu_zero, in_tag, out_illegal=0 into the output registers and enter HOLD (latency 1 cycle).
REQ-020 Accepted opcode 12-15 SHALL register result 0, zero 1, out_illegal 1, tag, and enter HOLD.
REQ-021 Accepted MUL SHALL load multiplicand=in_op1, multiplier=in_op2, accumulator=0, counter=0, capture tag, and enter MUL.
REQ-022 In MUL, each cycle: if multiplier[0] accumulator += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; counter++.
REQ-023 After exactly WIDTH MUL cycles, out_result SHALL equal low WIDTH bits of op1*op2 (unsigned), out_zero = (result==0), out_illegal=0, and the FSM enters HOLD; out_valid asserts cycle accept+WIDTH+1.
REQ-024 out_valid SHALL be 1 exactly in HOLD; out_* SHALL stay stable while out_valid && !out_ready.
REQ-025 In HOLD with out_ready=1 and no new accept, FSM SHALL go to IDLE.
REQ-026 In HOLD with out_ready=1 and accept, the new operation is processed per REQ-019..021 in the same cycle (1 op/cycle throughput for non-MUL).
REQ-027 No early termination of MUL; in_valid during MUL is ignored (not accepted).
REQ-028 Counter SHALL be $clog2(WIDTH)+1 bits wide so WIDTH counts without wrap.

Reset
REQ-029 reset SHALL force state IDLE, out_valid 0, out_result 0, out_zero 0, out_illegal 0, out_tag 0, busy 0, counter 0, accumulator 0.
REQ-030 reset asserted mid-MUL or in HOLD SHALL discard the operation; no out_valid until a new accept after reset deasserts.
REQ-031 reset SHALL take priority over any simultaneous handshake.

Structure
REQ-032 Opcode constants and FSM state enum SHALL live in shared package exec_pkg.
REQ-033 The shift-add multiplier datapath (multiplicand, multiplier, accumulator, counter) SHALL be a sub-module mul_seq with start/done ports; the FSM stays in exec_unit.
REQ-034 The ALU SHALL remain external; exec_unit contains no shift/logic datapath of its own.

Verification
REQ-035 ADD op1=5 op2=7 tag=3, out_ready=1 -> out_valid next cycle, result 12, zero 0, tag 3.
REQ-036 MUL 6*7 -> busy 32 cycles, out_valid at accept+33, result 42; MUL 0xFFFFFFFF*0xFFFFFFFF -> result 0x00000001.
REQ-037 MUL 0x10000*0x10000 -> result 0, zero 1, illegal 0.
REQ-038 ctrl=4'hF -> result 0, zero 1, illegal 1; in_valid during MUL -> in_ready 0, no extra result.
REQ-039 Back-to-back SUB 10-3, XOR 0xF0^0xFF, out_ready=1 -> results 7, 0x0F on consecutive cycles; out_ready held 0 for 5 cycles -> out_* stable, in_ready 0.
REQ-040 reset pulsed at MUL cycle 10 -> state IDLE, out_valid 0 afterwards; next ADD 1+1 -> 2 with normal latency.
